// File: rtl/input_debouncer_if.sv
// Bundle of the debouncer's per-channel signals: raw pins in, clean levels out, edge pulses.
// Ports: raw_in, clean_out, rise_pulse, fall_pulse (+ evt_clr, evt_sticky under DEBOUNCE_STICKY_EN).
interface input_debouncer_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
`ifdef DEBOUNCE_STICKY_EN
   logic [WIDTH-1:0] evt_clr;
   logic [WIDTH-1:0] evt_sticky;

   modport master (
      output raw_in,
      output evt_clr,
      input  clean_out,
      input  rise_pulse,
      input  fall_pulse,
      input  evt_sticky
   );

   modport slave (
      input  raw_in,
      input  evt_clr,
      output clean_out,
      output rise_pulse,
      output fall_pulse,
      output evt_sticky
   );
`else
   modport master (
      output raw_in,
      input  clean_out,
      input  rise_pulse,
      input  fall_pulse
   );

   modport slave (
      input  raw_in,
      output clean_out,
      output rise_pulse,
      output fall_pulse
   );
`endif
endinterface

// File: rtl/input_debouncer.sv
// Multi-channel synchronizer + counter debounce with registered rise/fall pulses.
// Ports: clk, rst_n (async, active-low), io (slave: raw_in, clean_out, rise_pulse, fall_pulse).
// Optional DEBOUNCE_STICKY_EN adds io.evt_clr / io.evt_sticky sticky event flags.
module input_debouncer #(
   parameter int   WIDTH           = 2,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   input_debouncer_if.slave io
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic {
      ST_STABLE,
      ST_COUNTING
   } state_t;

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;

   state_t          state_q [WIDTH];
   state_t          state_d [WIDTH];
   logic [CW-1:0]   cnt_q   [WIDTH];
   logic [CW-1:0]   cnt_d   [WIDTH];

   logic [WIDTH-1:0] clean_q, clean_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++)
            sync_r[s] <= {WIDTH{RESET_VAL}};
      end else begin
         sync_r[0] <= io.raw_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_r[s] <= sync_r[s-1];
      end
   end

   assign sync_q = sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
         clean_q <= {WIDTH{RESET_VAL}};
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Counter is 0 in ST_STABLE, so both states share the
   // "increment or flip" path; a flip happens on the edge the
   // count would reach DEBOUNCE_CYCLES, so it never saturates.
   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            ST_STABLE: begin
               cnt_d[i] = '0;
               if (sync_q[i] != clean_q[i]) begin
                  if (cnt_q[i] + CNT_ONE == CNT_MAX) begin
                     clean_d[i] = sync_q[i];
                     rise_d[i]  = sync_q[i];
                     fall_d[i]  = ~sync_q[i];
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CNT_ONE;
                     state_d[i] = ST_COUNTING;
                  end
               end
            end
            ST_COUNTING: begin
               if (sync_q[i] == clean_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else if (cnt_q[i] + CNT_ONE == CNT_MAX) begin
                  clean_d[i] = sync_q[i];
                  rise_d[i]  = sync_q[i];
                  fall_d[i]  = ~sync_q[i];
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
         endcase
      end
   end

   assign io.clean_out  = clean_q;
   assign io.rise_pulse = rise_q;
   assign io.fall_pulse = fall_q;

`ifdef DEBOUNCE_STICKY_EN
   logic [WIDTH-1:0] sticky_q;

   // Set term is OR'd after the clear mask so set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_q <= '0;
      else
         sticky_q <= (sticky_q & ~io.evt_clr)
                   | rise_q | fall_q;
   end

   assign io.evt_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (WIDTH=2, 2 sync stages, 4 debounce cycles).
// Checks reset, latency, glitch rejection, multi-channel flips, mid-count reset, sticky flags.
module tb_input_debouncer;
   localparam int W = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   input_debouncer_if #(.WIDTH(W)) bus ();

   input_debouncer #(
      .WIDTH          (W),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .RESET_VAL      (1'b0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b",
                tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic [1:0] c,
                          input logic [1:0] r,
                          input logic [1:0] f);
      chk(tag,
          {2'b00, bus.clean_out, bus.rise_pulse, bus.fall_pulse},
          {2'b00, c, r, f});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b1;
      bus.raw_in = 2'b00;
`ifdef DEBOUNCE_STICKY_EN
      bus.evt_clr = 2'b00;
`endif
      #1 rst_n = 1'b0;
      tick(2);
      chk_all("reset_state", 2'b00, 2'b00, 2'b00);
`ifdef DEBOUNCE_STICKY_EN
      chk("reset_sticky", {6'd0, bus.evt_sticky}, 8'h00);
`endif
      rst_n = 1'b1;

      // 1: idle after reset
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk_all("idle_hold", 2'b00, 2'b00, 2'b00);
      end

      // 2: ch0 rise, latency 6
      bus.raw_in = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk_all("rise_wait", 2'b00, 2'b00, 2'b00);
      end
      tick(1);
      chk_all("rise_edge6", 2'b01, 2'b01, 2'b00);
      tick(1);
      chk_all("rise_after", 2'b01, 2'b00, 2'b00);
      bus.raw_in = 2'b00;
      tick(5);
      chk_all("fall0_wait", 2'b01, 2'b00, 2'b00);
      tick(1);
      chk_all("fall0_edge6", 2'b00, 2'b00, 2'b01);
      tick(1);
      chk_all("fall0_after", 2'b00, 2'b00, 2'b00);

      // 3: 3-cycle glitch on ch1 rejected
      bus.raw_in = 2'b10;
      tick(3);
      bus.raw_in = 2'b00;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk_all("glitch_rej", 2'b00, 2'b00, 2'b00);
      end

      // 4: both channels together
      bus.raw_in = 2'b11;
      tick(5);
      chk_all("both_wait", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk_all("both_rise", 2'b11, 2'b11, 2'b00);
      tick(1);
      chk_all("both_hold", 2'b11, 2'b00, 2'b00);
      bus.raw_in = 2'b00;
      tick(5);
      chk_all("both_fwait", 2'b11, 2'b00, 2'b00);
      tick(1);
      chk_all("both_fall", 2'b00, 2'b00, 2'b11);
      tick(1);
      chk_all("both_fhold", 2'b00, 2'b00, 2'b00);

      // 5: reset mid-count restarts full latency
      bus.raw_in = 2'b01;
      tick(3);
      #4 rst_n = 1'b0;
      #1;
      chk_all("midrst_now", 2'b00, 2'b00, 2'b00);
      tick(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk_all("midrst_wait", 2'b00, 2'b00, 2'b00);
      end
      tick(1);
      chk_all("midrst_edge6", 2'b01, 2'b01, 2'b00);

      // async clear of a high output, then reconverge
      #3 rst_n = 1'b0;
      #1;
      chk_all("async_clr", 2'b00, 2'b00, 2'b00);
      tick(1);
      rst_n = 1'b1;
      tick(5);
      chk_all("post_wait", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk_all("post_rise", 2'b01, 2'b01, 2'b00);
      bus.raw_in = 2'b00;
      tick(6);
      chk_all("post_fall", 2'b00, 2'b00, 2'b01);
      tick(1);

`ifdef DEBOUNCE_STICKY_EN
      // 6: sticky event flags
      bus.evt_clr = 2'b11;
      tick(1);
      bus.evt_clr = 2'b00;
      chk("stk_cleared", {6'd0, bus.evt_sticky}, 8'h00);
      bus.raw_in = 2'b01;
      tick(6);
      chk_all("stk_rise", 2'b01, 2'b01, 2'b00);
      tick(1);
      chk("stk_set_r", {6'd0, bus.evt_sticky}, 8'h01);
      bus.evt_clr = 2'b01;
      tick(1);
      bus.evt_clr = 2'b00;
      chk("stk_clr1", {6'd0, bus.evt_sticky}, 8'h00);
      bus.raw_in = 2'b00;
      tick(6);
      chk_all("stk_fall", 2'b00, 2'b00, 2'b01);
      tick(1);
      chk("stk_set_f", {6'd0, bus.evt_sticky}, 8'h01);
      bus.raw_in = 2'b01;
      tick(6);
      chk_all("stk_rise2", 2'b01, 2'b01, 2'b00);
      bus.evt_clr = 2'b01;
      tick(1);
      bus.evt_clr = 2'b00;
      chk("stk_set_win", {6'd0, bus.evt_sticky}, 8'h01);
      bus.evt_clr = 2'b01;
      tick(1);
      bus.evt_clr = 2'b00;
      chk("stk_idle_clr", {6'd0, bus.evt_sticky}, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
